regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between two writeback requesters: the ALU/execute path (requester A) and the load/memory path (requester B). Each requester uses a valid/ready handshake. The block grants one requester per cycle under round-robin priority and registers the winning write into a one-stage output buffer. That buffer drives the register file's write address, data, new-flags and update-flags inputs, plus a write-enable that the datapath uses to gate the register file's unconditional write.

---
 rtl/regfile_write_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter sharing the register-file write port
//               between the ALU (A) and load (B) paths via a 1-stage buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 3,
  parameter int FLAGS_ADDRESS = 7
) (
  input  logic                     Clk,
  input  logic                     RstN,
  input  logic                     AValid,
  output logic                     AReady,
  input  logic [ADDR_WIDTH-1:0]    AAddr,
  input  logic [DATA_WIDTH-1:0]    AData,
  input  logic [DATA_WIDTH-1:0]    AFlags,
  input  logic                     AFlagsEn,
  input  logic                     BValid,
  output logic                     BReady,
  input  logic [ADDR_WIDTH-1:0]    BAddr,
  input  logic [DATA_WIDTH-1:0]    BData,
  input  logic [DATA_WIDTH-1:0]    BFlags,
  input  logic                     BFlagsEn,
  output logic                     WrEn,
  output logic [ADDR_WIDTH-1:0]    WrAddr,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    WrNewFlags,
  output logic                     WrUpdateFlags,
  output logic [(1<<ADDR_WIDTH)-1:0] RegBusy
);

  localparam int c_REG_COUNT = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t r_pri;
  pri_t w_priNext;
  logic w_grantA;
  logic w_grantB;

  logic                  r_wrEn;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [DATA_WIDTH-1:0] r_wrData;
  logic [DATA_WIDTH-1:0] r_wrNewFlags;
  logic                  r_wrUpdateFlags;
  logic [c_REG_COUNT-1:0] w_regBusy;

  // Grants are gated by RstN so neither requester sees Ready while in reset.
  always_comb begin
    w_grantA  = 1'b0;
    w_grantB  = 1'b0;
    w_priNext = r_pri;
    if (RstN) begin
      w_grantA = AValid && (!BValid || (r_pri == PRI_A));
      w_grantB = BValid && (!AValid || (r_pri == PRI_B));
    end
    if (w_grantA) begin
      w_priNext = PRI_B;
    end else if (w_grantB) begin
      w_priNext = PRI_A;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_pri <= PRI_A;
    end else begin
      r_pri <= w_priNext;
    end
  end

  // Output buffer: always drained next cycle, so it is reloaded every edge.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_wrEn          <= 1'b0;
      r_wrAddr        <= '0;
      r_wrData        <= '0;
      r_wrNewFlags    <= '0;
      r_wrUpdateFlags <= 1'b0;
    end else begin
      r_wrEn          <= w_grantA || w_grantB;
      r_wrUpdateFlags <= 1'b0;
      if (w_grantA) begin
        r_wrAddr        <= AAddr;
        r_wrData        <= AData;
        r_wrNewFlags    <= AFlags;
        r_wrUpdateFlags <= AFlagsEn;
      end else if (w_grantB) begin
        r_wrAddr        <= BAddr;
        r_wrData        <= BData;
        r_wrNewFlags    <= BFlags;
        r_wrUpdateFlags <= BFlagsEn;
      end
    end
  end

  always_comb begin
    w_regBusy = '0;
    if (r_wrEn) begin
      w_regBusy[r_wrAddr] = 1'b1;
    end
    if (r_wrUpdateFlags) begin
      w_regBusy[FLAGS_ADDRESS] = 1'b1;
    end
  end

  assign AReady        = w_grantA;
  assign BReady        = w_grantB;
  assign WrEn          = r_wrEn;
  assign WrAddr        = r_wrAddr;
  assign WrData        = r_wrData;
  assign WrNewFlags    = r_wrNewFlags;
  assign WrUpdateFlags = r_wrUpdateFlags;
  assign RegBusy       = w_regBusy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Vector table, corner sequences and random model-based checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        RstN;
  logic        AValid, AReady, AFlagsEn;
  logic [2:0]  AAddr;
  logic [15:0] AData, AFlags;
  logic        BValid, BReady, BFlagsEn;
  logic [2:0]  BAddr;
  logic [15:0] BData, BFlags;
  logic        WrEn, WrUpdateFlags;
  logic [2:0]  WrAddr;
  logic [15:0] WrData, WrNewFlags;
  logic [7:0]  RegBusy;

  int checks;
  int errors;

  regfile_write_arbiter #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .FLAGS_ADDRESS(7)
  ) dut (
    .Clk(Clk), .RstN(RstN),
    .AValid(AValid), .AReady(AReady), .AAddr(AAddr), .AData(AData),
    .AFlags(AFlags), .AFlagsEn(AFlagsEn),
    .BValid(BValid), .BReady(BReady), .BAddr(BAddr), .BData(BData),
    .BFlags(BFlags), .BFlagsEn(BFlagsEn),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrNewFlags(WrNewFlags),
    .WrUpdateFlags(WrUpdateFlags), .RegBusy(RegBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        aV;  logic [2:0] aAddr; logic [15:0] aData; logic [15:0] aFlags; logic aFE;
    logic        bV;  logic [2:0] bAddr; logic [15:0] bData; logic [15:0] bFlags; logic bFE;
    logic        expAR; logic expBR; logic expEn; logic [2:0] expAddr;
    logic [15:0] expData; logic [15:0] expNewFlags; logic expUpd; logic [7:0] expBusy;
  } vec_t;

  typedef struct {
    logic        en;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] flags;
    logic        fe;
  } wr_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    AValid = 1'b0; AAddr = 3'd0; AData = 16'h0; AFlags = 16'h0; AFlagsEn = 1'b0;
    BValid = 1'b0; BAddr = 3'd0; BData = 16'h0; BFlags = 16'h0; BFlagsEn = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    AValid = 1'b1;
    BValid = 1'b1;
    RstN   = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_WrEn", WrEn, 1'b0);
    chk("rst_WrUpdateFlags", WrUpdateFlags, 1'b0);
    chk("rst_WrAddr", WrAddr, 3'd0);
    chk("rst_WrData", WrData, 16'h0);
    chk("rst_WrNewFlags", WrNewFlags, 16'h0);
    chk("rst_RegBusy", RegBusy, 8'h00);
    chk("rst_AReady", AReady, 1'b0);
    chk("rst_BReady", BReady, 1'b0);
    clearInputs();
    @(negedge Clk);
    RstN = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] busyOf(input logic [2:0] addr, input logic fe);
    logic [7:0] b;
    b = 8'h01 << addr;
    if (fe) b = b | 8'h80;
    return b;
  endfunction

  vec_t vecs[9];
  wr_t  q[$];

  initial begin
    checks = 0;
    errors = 0;
    clearInputs();
    RstN = 1'b1;

    vecs[0] = '{1'b1, 3'd3, 16'h1234, 16'h0000, 1'b0,  1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0,
                1'b1, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h0000, 1'b0, 8'h08};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0,  1'b1, 3'd5, 16'h5555, 16'h0003, 1'b1,
                1'b0, 1'b1, 1'b1, 3'd5, 16'h5555, 16'h0003, 1'b1, 8'hA0};
    vecs[2] = '{1'b1, 3'd1, 16'h1111, 16'h0000, 1'b0,  1'b1, 3'd2, 16'h2222, 16'h0000, 1'b0,
                1'b1, 1'b0, 1'b1, 3'd1, 16'h1111, 16'h0000, 1'b0, 8'h02};
    vecs[3] = '{1'b1, 3'd1, 16'h1111, 16'h0000, 1'b0,  1'b1, 3'd2, 16'h2222, 16'h0000, 1'b0,
                1'b0, 1'b1, 1'b1, 3'd2, 16'h2222, 16'h0000, 1'b0, 8'h04};
    vecs[4] = vecs[2];
    vecs[5] = vecs[3];
    vecs[6] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0,  1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0,
                1'b0, 1'b0, 1'b0, 3'd2, 16'h2222, 16'h0000, 1'b0, 8'h00};
    vecs[7] = '{1'b1, 3'd7, 16'hABCD, 16'h00F0, 1'b1,  1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0,
                1'b1, 1'b0, 1'b1, 3'd7, 16'hABCD, 16'h00F0, 1'b1, 8'h80};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0,  1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0,
                1'b0, 1'b0, 1'b0, 3'd7, 16'hABCD, 16'h0000, 1'b0, 8'h00};

    doReset();

    // Directed vectors: Ready checked mid-cycle, buffer contents after the edge.
    for (int i = 0; i < 9; i++) begin
      AValid = vecs[i].aV; AAddr = vecs[i].aAddr; AData = vecs[i].aData;
      AFlags = vecs[i].aFlags; AFlagsEn = vecs[i].aFE;
      BValid = vecs[i].bV; BAddr = vecs[i].bAddr; BData = vecs[i].bData;
      BFlags = vecs[i].bFlags; BFlagsEn = vecs[i].bFE;
      @(negedge Clk);
      chk($sformatf("vec%0d_AReady", i), AReady, vecs[i].expAR);
      chk($sformatf("vec%0d_BReady", i), BReady, vecs[i].expBR);
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_WrEn", i), WrEn, vecs[i].expEn);
      chk($sformatf("vec%0d_WrAddr", i), WrAddr, vecs[i].expAddr);
      chk($sformatf("vec%0d_WrData", i), WrData, vecs[i].expData);
      chk($sformatf("vec%0d_WrUpdateFlags", i), WrUpdateFlags, vecs[i].expUpd);
      chk($sformatf("vec%0d_RegBusy", i), RegBusy, vecs[i].expBusy);
      if (vecs[i].expEn)
        chk($sformatf("vec%0d_WrNewFlags", i), WrNewFlags, vecs[i].expNewFlags);
    end

    // Asynchronous reset while a write sits in the buffer.
    clearInputs();
    AValid = 1'b1; AAddr = 3'd4; AData = 16'h4444; AFlagsEn = 1'b1;
    @(posedge Clk);
    #1;
    chk("midrst_pre_WrEn", WrEn, 1'b1);
    #2;
    RstN = 1'b0;
    #1;
    chk("midrst_WrEn", WrEn, 1'b0);
    chk("midrst_RegBusy", RegBusy, 8'h00);
    chk("midrst_WrUpdateFlags", WrUpdateFlags, 1'b0);
    chk("midrst_WrAddr", WrAddr, 3'd0);
    chk("midrst_AReady", AReady, 1'b0);
    AAddr = 3'd6; AData = 16'h6666; AFlagsEn = 1'b0;
    BValid = 1'b1; BAddr = 3'd1; BData = 16'h0101;
    #1;
    chk("midrst_AReady_held", AReady, 1'b0);
    chk("midrst_BReady_held", BReady, 1'b0);
    @(posedge Clk);
    #1;
    chk("midrst_noload_WrEn", WrEn, 1'b0);
    @(negedge Clk);
    RstN = 1'b1;
    #1;
    chk("postrst_AReady", AReady, 1'b1);
    chk("postrst_BReady", BReady, 1'b0);
    @(posedge Clk);
    #1;
    chk("postrst_WrEn", WrEn, 1'b1);
    chk("postrst_WrAddr", WrAddr, 3'd6);
    chk("postrst_WrData", WrData, 16'h6666);

    // Random stress against a last-winner model and a write queue.
    doReset();
    begin
      logic aPri;
      logic gA, gB;
      logic [31:0] r;
      wr_t e;
      aPri = 1'b1;
      q.delete();
      for (int cyc = 0; cyc < 2000; cyc++) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rnd_WrEn", WrEn, e.en);
          if (e.en) begin
            chk("rnd_WrAddr", WrAddr, e.addr);
            chk("rnd_WrData", WrData, e.data);
            chk("rnd_WrNewFlags", WrNewFlags, e.flags);
            chk("rnd_WrUpdateFlags", WrUpdateFlags, e.fe);
            chk("rnd_RegBusy", RegBusy, busyOf(e.addr, e.fe));
          end else begin
            chk("rnd_idle_WrUpdateFlags", WrUpdateFlags, 1'b0);
            chk("rnd_idle_RegBusy", RegBusy, 8'h00);
          end
        end
        r = $urandom;
        AValid = r[0]; AFlagsEn = r[1]; AAddr = r[4:2];
        BValid = r[5]; BFlagsEn = r[6]; BAddr = r[9:7];
        r = $urandom; AData = r[15:0]; BData = r[31:16];
        r = $urandom; AFlags = r[15:0]; BFlags = r[31:16];
        #1;
        gA = AValid && (!BValid || aPri);
        gB = BValid && !gA;
        chk("rnd_AReady", AReady, gA);
        chk("rnd_BReady", BReady, gB);
        if (gA) begin
          aPri = 1'b0;
          q.push_back('{1'b1, AAddr, AData, AFlags, AFlagsEn});
        end else if (gB) begin
          aPri = 1'b1;
          q.push_back('{1'b1, BAddr, BData, BFlags, BFlagsEn});
        end else begin
          q.push_back('{1'b0, 3'd0, 16'h0, 16'h0, 1'b0});
        end
        @(posedge Clk);
        #1;
      end
      clearInputs();
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_last_WrEn", WrEn, e.en);
        if (e.en) chk("rnd_last_WrAddr", WrAddr, e.addr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
